move_cmd_gen: RTL
=================

MOVE_CMD_GEN -- requirements
Module: move_cmd_gen

Interface
REQ-001 SHALL have parameter REPEAT_DELAY, default 30_000_000, clk cycles a direction must be held before auto-repeat starts (300 ms at 100 MHz).
REQ-002 SHALL have parameter REPEAT_PERIOD, default 10_000_000, clk cycles between auto-repeat commands (100 ms).
REQ-003 SHALL have port clk  input  1  system clock; single clock domain.
REQ-004 SHALL have port rst  input  1  reset; asynchronous, active-low.
REQ-005 SHALL have port btn_up, btn_down, btn_left, btn_right  input  1 each  debounced board-button levels.
REQ-006 SHALL have port key_down  input  512  PS/2 key-state vector from the keyboard decoder.
REQ-007 SHALL have port cmd_ready  input  1  player accepts the presented move command.
REQ-008 SHALL have port cmd_valid  output  1  move command pending.
REQ-009 SHALL have port cmd_dir  output  3  direction: 0 none, 1 up, 2 down, 3 left, 4 right.
REQ-010 SHALL have port skill_pulse  output  1  one-cycle special-attack request.

Function
REQ-011 SHALL form each direction level as button OR key_down bit (up 0x075, down 0x072, left 0x06B, right 0x074), registered once before use.
REQ-012 SHALL resolve simultaneous levels by fixed priority: up > down > left > right; the active direction is the winner, or 0 if none.
REQ-013 SHALL implement FSM IDLE -> DELAY -> REPEAT.
- IDLE: active direction goes nonzero -> issue command, load counter with REPEAT_DELAY, go to DELAY.
- DELAY: counter reaches 0 -> issue command, load REPEAT_PERIOD, go to REPEAT.
- REPEAT: counter reaches 0 -> issue command, reload REPEAT_PERIOD.
REQ-014 SHALL return to IDLE in the cycle after the active direction becomes 0, from any state, without issuing a command.
REQ-015 SHALL treat a change of active direction to another nonzero value in DELAY or REPEAT as a new press: issue the new direction, reload REPEAT_DELAY, go to DELAY.
REQ-016 SHALL assert cmd_valid one clk after the event that issues a command.
REQ-017 SHALL hold cmd_valid and cmd_dir stable until a cycle with cmd_valid and cmd_ready both high; the command is consumed in that cycle.
REQ-018 SHALL latch a new-press or direction-change command arriving while one is pending into a single skid entry; a later press overwrites the skid entry; the skid entry is presented the cycle after acceptance.
REQ-019 SHALL drop auto-repeat commands that arrive while a command is pending; they are never queued.
REQ-020 SHALL drive cmd_dir to 0 whenever cmd_valid is low.
REQ-021 SHALL pulse skill_pulse high for exactly one cycle on the rising edge of the registered key_down[0x069] level; no repeat and no handshake.
REQ-022 SHALL size the counter to ceil(log2(max(REPEAT_DELAY, REPEAT_PERIOD)+1)) bits; it counts down and saturates at 0.

Reset
REQ-023 SHALL, while rst is low, force state IDLE, counter 0, cmd_valid 0, cmd_dir 0, skill_pulse 0, skid entry empty, and registered levels 0.
REQ-024 SHALL issue a command for a direction already held when rst deasserts, on the second clk after deassertion (IDLE sees it as a new press).
REQ-025 SHALL discard a pending command and the skid entry when reset is asserted mid-handshake.

Structure
REQ-026 SHALL place the direction encoding (0-4) and scan codes 0x075, 0x072, 0x06B, 0x074, 0x069 in the shared game package, reused by the player and shortest-path blocks.
REQ-027 SHALL implement the load/down-count/zero-flag counter as sub-module repeat_timer.

Verification
REQ-028 SHALL test a single press: btn_up held 5 cycles with REPEAT_DELAY=20 and REPEAT_PERIOD=8 (cmd_ready=1) -> exactly one cmd_valid cycle, cmd_dir=1, no repeat.
REQ-029 SHALL test auto-repeat: key 0x074 held 50 cycles with the same parameters -> cmd_dir=4 commands at t+1, t+21, t+29, t+37, t+45.
REQ-030 SHALL test priority and direction change: btn_left and btn_down together -> cmd_dir=2; then btn_down released -> cmd_dir=3 issued immediately and DELAY restarted.
REQ-031 SHALL test back-pressure: cmd_ready=0 with presses up then left, then auto-repeat -> cmd_dir=1 stays stable, cmd_dir=3 is presented the cycle after acceptance, repeats are dropped.
REQ-032 SHALL test the skill key: key_down[0x069] held 100 cycles -> exactly one skill_pulse.
REQ-033 SHALL test reset mid-handshake: rst low while cmd_valid=1 -> all outputs are 0 within the same cycle (asynchronous); a held direction reissues 2 clks after release.

Source files
------------

// File: rtl/move_cmd_gen_pkg.sv
// rtl/move_cmd_gen_pkg.sv - shared game encodings: move directions, PS/2 scan codes, FSM states
package move_cmd_gen_pkg;

    typedef enum logic [2:0] {
        DIR_NONE  = 3'd0,
        DIR_UP    = 3'd1,
        DIR_DOWN  = 3'd2,
        DIR_LEFT  = 3'd3,
        DIR_RIGHT = 3'd4
    } dir_t;

    localparam logic [8:0] SC_UP    = 9'h075;
    localparam logic [8:0] SC_DOWN  = 9'h072;
    localparam logic [8:0] SC_LEFT  = 9'h06B;
    localparam logic [8:0] SC_RIGHT = 9'h074;
    localparam logic [8:0] SC_SKILL = 9'h069;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DELAY  = 2'd1,
        ST_REPEAT = 2'd2
    } move_state_t;

    // Fixed priority: up > down > left > right.
    function automatic dir_t resolve_dir(input logic up, input logic down,
                                         input logic left, input logic right);
        if (up)    return DIR_UP;
        if (down)  return DIR_DOWN;
        if (left)  return DIR_LEFT;
        if (right) return DIR_RIGHT;
        return DIR_NONE;
    endfunction

endpackage

// File: rtl/move_cmd_gen_repeat_timer.sv
// rtl/move_cmd_gen_repeat_timer.sv - loadable down-counter, saturating at zero
module repeat_timer #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         zero_next
);

    logic [W-1:0] count;

    // High on the edge where the count steps from 1 to 0, so a load of N expires N edges later.
    assign zero_next = (count == W'(1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (count != '0) begin
            count <= count - W'(1);
        end
    end

endmodule

// File: rtl/move_cmd_gen.sv
// rtl/move_cmd_gen.sv - button/keyboard to move-command generator with auto-repeat and skid entry
module move_cmd_gen
    import move_cmd_gen_pkg::*;
#(
    parameter int REPEAT_DELAY  = 30_000_000,
    parameter int REPEAT_PERIOD = 10_000_000
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         btn_up,
    input  logic         btn_down,
    input  logic         btn_left,
    input  logic         btn_right,
    input  logic [511:0] key_down,
    input  logic         cmd_ready,
    output logic         cmd_valid,
    output logic [2:0]   cmd_dir,
    output logic         skill_pulse
);

    localparam int CNT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] DELAY_LD  = CNT_W'(REPEAT_DELAY);
    localparam logic [CNT_W-1:0] PERIOD_LD = CNT_W'(REPEAT_PERIOD);

    logic lvl_up, lvl_down, lvl_left, lvl_right, lvl_skill, skill_prev;
    dir_t act_dir;
    dir_t cur_dir;
    dir_t out_dir;
    dir_t skid_dir;
    logic skid_valid;
    move_state_t state;

    logic issue_press, issue_repeat, timer_load, timer_zero, slot_free;
    logic [CNT_W-1:0] timer_val;

    // Only five scan codes matter; the rest of the key vector is intentionally ignored.
    logic unused_keys;
    assign unused_keys = ^key_down;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lvl_up     <= 1'b0;
            lvl_down   <= 1'b0;
            lvl_left   <= 1'b0;
            lvl_right  <= 1'b0;
            lvl_skill  <= 1'b0;
            skill_prev <= 1'b0;
        end else begin
            lvl_up     <= btn_up    | key_down[SC_UP];
            lvl_down   <= btn_down  | key_down[SC_DOWN];
            lvl_left   <= btn_left  | key_down[SC_LEFT];
            lvl_right  <= btn_right | key_down[SC_RIGHT];
            lvl_skill  <= key_down[SC_SKILL];
            skill_prev <= lvl_skill;
        end
    end

    assign act_dir = resolve_dir(lvl_up, lvl_down, lvl_left, lvl_right);

    always_comb begin
        issue_press  = 1'b0;
        issue_repeat = 1'b0;
        timer_load   = 1'b0;
        timer_val    = DELAY_LD;
        if (act_dir != DIR_NONE) begin
            if (state == ST_IDLE || act_dir != cur_dir) begin
                issue_press = 1'b1;
                timer_load  = 1'b1;
            end else if (timer_zero) begin
                issue_repeat = 1'b1;
                timer_load   = 1'b1;
                timer_val    = PERIOD_LD;
            end
        end
    end

    assign slot_free = !cmd_valid || cmd_ready;

    repeat_timer #(
        .W(CNT_W)
    ) u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (timer_load),
        .load_val (timer_val),
        .zero_next(timer_zero)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= ST_IDLE;
            cur_dir     <= DIR_NONE;
            cmd_valid   <= 1'b0;
            out_dir     <= DIR_NONE;
            skid_valid  <= 1'b0;
            skid_dir    <= DIR_NONE;
            skill_pulse <= 1'b0;
        end else begin
            if (act_dir == DIR_NONE) begin
                state <= ST_IDLE;
            end else if (issue_press) begin
                state   <= ST_DELAY;
                cur_dir <= act_dir;
            end else if (issue_repeat) begin
                state <= ST_REPEAT;
            end

            // Presses queue behind a pending command in one skid slot; repeats never queue.
            if (slot_free) begin
                if (skid_valid) begin
                    cmd_valid  <= 1'b1;
                    out_dir    <= skid_dir;
                    skid_valid <= issue_press;
                    skid_dir   <= act_dir;
                end else if (issue_press || issue_repeat) begin
                    cmd_valid <= 1'b1;
                    out_dir   <= act_dir;
                end else begin
                    cmd_valid <= 1'b0;
                    out_dir   <= DIR_NONE;
                end
            end else if (issue_press) begin
                skid_valid <= 1'b1;
                skid_dir   <= act_dir;
            end

            skill_pulse <= lvl_skill & ~skill_prev;
        end
    end

    assign cmd_dir = out_dir;

endmodule
